// File: rtl/seq_det_pkg.sv
// Shared defaults for the serial pattern detector and its status counter.
package seq_det_pkg;

  localparam int LEN_DEF   = 4;
  localparam int CNT_W_DEF = 8;

  localparam logic [3:0] PAT_RST_DEF = 4'b1011;

  // fill must hold 0..LEN-1; keep at least one bit for the LEN=2 case
  function automatic int fill_w(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; a clear coinciding with an
// event restarts the count at one so that event is not lost.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
    sat_d = (count_d == CNT_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count_o = count_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable LEN-bit serial pattern detector with zero-latency
// Mealy match, selectable overlap and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = LEN_DEF,
  parameter int             CNT_W   = CNT_W_DEF,
  parameter logic [LEN-1:0] PAT_RST = LEN'(PAT_RST_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             x,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_i,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam int             FW        = fill_w(LEN);
  localparam logic [FW-1:0]  FILL_FULL = FW'(LEN - 1);

  logic [LEN-1:0] pat_q, pat_d;
  logic [LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]  fill_q, fill_d;

  logic [LEN-1:0] window;
  logic           take_bit;

  assign window   = {hist_q, x};
  assign take_bit = in_valid && !pat_load;
  assign match    = !rst && take_bit && (fill_q == FILL_FULL) && (window == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (pat_load) begin
      pat_d  = pat_i;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = window[LEN-2:0];
      // non-overlap: the matched bits may not be reused by the next match
      if (match && !overlap_en) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= PAT_RST;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (match),
    .clr_i  (count_clr),
    .count_o(count),
    .sat_o  (sat)
  );

endmodule
